data_sram_responder: RTL and testbench

//   Responder side of the data SRAM port driven by the execute stage.

---
 rtl/data_sram_responder.sv | 192 +++++++++++++++++++
 tb/tb_data_sram_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder
// Description : Responder for the core's data_sram_* bus. Single-ported,
//               word-organised RAM with byte-strobed writes and synchronous
//               reads, a read-valid strobe, a sticky out-of-window error flag
//               and saturating read/write request counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W     word-index width, DEPTH = 2**ADDR_W words
//   BASE_ADDR  byte address of word 0 (4-byte aligned)
// Ports
//   clk              in   1   clock, all state on rising edge
//   reset            in   1   asynchronous active-high reset
//   data_sram_en     in   1   access request this cycle
//   data_sram_we     in   4   byte write strobes, 4'b0000 = read
//   data_sram_addr   in   32  byte address, bits [1:0] ignored
//   data_sram_wdata  in   32  write data, lane i = wdata[8i+7:8i]
//   data_sram_rdata  out  32  read data (held between reads)
//   data_sram_rvalid out  1   one-cycle strobe per read result
//   err_oob          out  1   sticky: an access fell outside the window
//   rd_cnt           out  32  accepted reads, saturating
//   wr_cnt           out  32  accepted writes, saturating
// Build option
//   DATA_SRAM_LAT2_EN : adds an output register stage, so rdata/rvalid
//                       arrive two cycles after the request (still one read
//                       per cycle). err_oob and the counters are unaffected.
// ============================================================================
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        err_oob,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned DEPTH     = 32'd1 << ADDR_W;
  // Window size in bytes; 33 bits so a 2**32-byte window still compares.
  localparam logic [32:0] WIN_BYTES = 33'd1 << (ADDR_W + 2);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] index;
  logic              rd_req;
  logic              wr_req;

  // Offset wraps modulo 2**32, so addresses below BASE_ADDR land far above
  // the window and are flagged out of range.
  assign off      = data_sram_addr - BASE_ADDR;
  assign in_range = ({1'b0, off} < WIN_BYTES);
  assign index    = off[ADDR_W+1:2];
  assign rd_req   = data_sram_en && (data_sram_we == 4'b0000);
  assign wr_req   = data_sram_en && (data_sram_we != 4'b0000);

  // --------------------------------------------------------------------------
  // Storage (contents are not reset)
  // --------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_req && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem[index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Out-of-window reads return zero rather than an aliased word.
  always_comb begin
    rd_word = 32'h0;
    if (in_range) begin
      rd_word = mem[index];
    end
  end

  // --------------------------------------------------------------------------
  // First read-result stage: captured at the request edge
  // --------------------------------------------------------------------------
  logic        rvalid_d, rvalid_q;
  logic [31:0] rdata_d,  rdata_q;

  always_comb begin
    rvalid_d = rd_req;
    rdata_d  = rdata_q;
    if (rd_req) begin
      rdata_d = rd_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef DATA_SRAM_LAT2_EN
  // --------------------------------------------------------------------------
  // Second read-result stage: data only advances with a valid result so the
  // output holds the last read between reads, matching the 1-cycle build.
  // --------------------------------------------------------------------------
  logic        out_valid_d, out_valid_q;
  logic [31:0] out_data_d,  out_data_q;

  always_comb begin
    out_valid_d = rvalid_q;
    out_data_d  = out_data_q;
    if (rvalid_q) begin
      out_data_d = rdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign data_sram_rvalid = out_valid_q;
  assign data_sram_rdata  = out_data_q;
`else
  assign data_sram_rvalid = rvalid_q;
  assign data_sram_rdata  = rdata_q;
`endif

  // --------------------------------------------------------------------------
  // Error flag and saturating counters
  // --------------------------------------------------------------------------
  logic        err_oob_d, err_oob_q;
  logic [31:0] rd_cnt_d,  rd_cnt_q;
  logic [31:0] wr_cnt_d,  wr_cnt_q;

  always_comb begin
    err_oob_d = err_oob_q | (data_sram_en & ~in_range);
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (rd_req && (rd_cnt_q != CNT_MAX)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_req && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_oob_q <= 1'b0;
      rd_cnt_q  <= 32'h0;
      wr_cnt_q  <= 32'h0;
    end else begin
      err_oob_q <= err_oob_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign err_oob = err_oob_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_responder
// Description : Self-checking bench for data_sram_responder. Randomized
//               traffic against a word-array reference model, directed
//               corner sequences, and a table of hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [31:0] WIN    = 32'd4 << ADDR_W;
`ifdef DATA_SRAM_LAT2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err_oob;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  data_sram_responder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_sram_en     (en),
    .data_sram_we     (we),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .err_oob          (err_oob),
    .rd_cnt           (rd_cnt),
    .wr_cnt           (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [16];
  logic [31:0] m_rd_cnt, m_wr_cnt;
  logic        m_err;
  logic [31:0] m_hold;     // last read result
  logic        prev_v;     // previous cycle's result, for the 2-cycle build
  logic [31:0] prev_d;

  task automatic model_reset();
    m_rd_cnt = 32'h0;
    m_wr_cnt = 32'h0;
    m_err    = 1'b0;
    m_hold   = 32'h0;
    prev_v   = 1'b0;
    prev_d   = 32'h0;
  endtask

  task automatic step(input logic i_en, input logic [3:0] i_we,
                      input logic [31:0] i_addr, input logic [31:0] i_wd);
    logic [31:0] off;
    logic        inr;
    int          idx;
    logic        cur_v;
    logic [31:0] cur_d;
    logic        ev;
    logic [31:0] ed;
    en = i_en; we = i_we; addr = i_addr; wdata = i_wd;
    off   = i_addr - BASE;
    inr   = (off < WIN);
    idx   = int'(off >> 2);
    cur_v = 1'b0;
    cur_d = m_hold;
    if (i_en && !inr) m_err = 1'b1;
    if (i_en && i_we == 4'b0000) begin
      cur_v  = 1'b1;
      cur_d  = inr ? m_mem[idx] : 32'h0;
      m_hold = cur_d;
      if (m_rd_cnt != 32'hFFFF_FFFF) m_rd_cnt = m_rd_cnt + 1;
    end else if (i_en) begin
      if (inr) begin
        for (int b = 0; b < 4; b++)
          if (i_we[b]) m_mem[idx][8*b +: 8] = i_wd[8*b +: 8];
      end
      if (m_wr_cnt != 32'hFFFF_FFFF) m_wr_cnt = m_wr_cnt + 1;
    end
    if (LAT == 1) begin
      ev = cur_v; ed = cur_d;
    end else begin
      ev = prev_v; ed = prev_d;
    end
    prev_v = cur_v;
    prev_d = cur_d;
    tick();
    chk("rvalid", {31'h0, rvalid}, {31'h0, ev});
    chk("rdata", rdata, ed);
    chk("err_oob", {31'h0, err_oob}, {31'h0, m_err});
    chk("rd_cnt", rd_cnt, m_rd_cnt);
    chk("wr_cnt", wr_cnt, m_wr_cnt);
  endtask

  task automatic do_reset();
    en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  initial begin
    int          r;
    int          w;
    logic [31:0] a;
    int          j;
    logic        ev;
    logic [31:0] ed;
    total = 0;
    bad   = 0;

    tbl[0]  = '{1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 4'h0, BASE + 32'h10, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 4'h2, BASE + 32'h10, 32'h0000_5500, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 4'h0, BASE + 32'h10, 32'h0,         1'b1, 32'hDEAD_55EF};
    tbl[4]  = '{1'b1, 4'h0, BASE + 32'h13, 32'h0,         1'b1, 32'hDEAD_55EF};
    tbl[5]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 32'hDEAD_55EF};
    tbl[6]  = '{1'b1, 4'hF, BASE + 32'h0,  32'h1122_3344, 1'b0, 32'hDEAD_55EF};
    tbl[7]  = '{1'b1, 4'hF, BASE + 32'h4,  32'h5566_7788, 1'b0, 32'hDEAD_55EF};
    tbl[8]  = '{1'b1, 4'h9, BASE + 32'h4,  32'hAABB_CCDD, 1'b0, 32'hDEAD_55EF};
    tbl[9]  = '{1'b1, 4'h0, BASE + 32'h4,  32'h0,         1'b1, 32'hAA66_77DD};
    tbl[10] = '{1'b1, 4'h0, BASE + 32'h0,  32'h0,         1'b1, 32'h1122_3344};
    tbl[11] = '{1'b1, 4'hF, BASE + 32'h8,  32'h0BAD_F00D, 1'b0, 32'h1122_3344};
    tbl[12] = '{1'b1, 4'h0, BASE + 32'h8,  32'h0,         1'b1, 32'h0BAD_F00D};

    // ---- reset state ----
    do_reset();
    chk("reset rvalid", {31'h0, rvalid}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset err", {31'h0, err_oob}, 32'h0);
    chk("reset rd_cnt", rd_cnt, 32'h0);
    chk("reset wr_cnt", wr_cnt, 32'h0);

    // ---- initialise the first 16 words so every model read is defined ----
    for (int i = 0; i < 16; i++) step(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);

    // ---- OOB read, then OOB write aliasing word 0 must not touch it ----
    step(1'b1, 4'h0, BASE + WIN, 32'h0);
    step(1'b1, 4'hF, BASE + WIN, 32'h5A5A_5A5A);
    step(1'b1, 4'h0, BASE, 32'h0);
    step(1'b1, 4'h0, BASE - 32'd4, 32'h0);

    // ---- back-to-back reads ----
    step(1'b1, 4'h0, BASE + 32'h0, 32'h0);
    step(1'b1, 4'h0, BASE + 32'h4, 32'h0);
    step(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      w = $urandom_range(0, 39);
      if (w < 16)       a = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
      else if (w < 38)  a = BASE + 32'(4 * (w % 16));
      else if (w == 38) a = BASE + WIN + 32'($urandom_range(0, 255));
      else              a = BASE - 32'd1 - 32'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 4)      step(1'b1, 4'h0, a, 32'h0);
      else if (r < 8) step(1'b1, 4'($urandom_range(1, 15)), a, $urandom);
      else            step(1'b0, 4'($urandom_range(0, 15)), a, $urandom);
    end

    // ---- counter saturation ----
    force dut.rd_cnt_d = 32'hFFFF_FFFE;
    force dut.wr_cnt_d = 32'hFFFF_FFFE;
    m_rd_cnt = 32'hFFFF_FFFE;
    m_wr_cnt = 32'hFFFF_FFFE;
    step(1'b0, 4'h0, BASE, 32'h0);
    release dut.rd_cnt_d;
    release dut.wr_cnt_d;
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
    chk("rd_cnt sat", rd_cnt, 32'hFFFF_FFFF);
    chk("wr_cnt sat", wr_cnt, 32'hFFFF_FFFF);

    // ---- asynchronous reset during a valid read result ----
    step(1'b1, 4'hF, BASE + 32'h4, 32'hCAFE_F00D);
    step(1'b1, 4'h0, BASE + 32'h4, 32'h0);
    if (LAT == 2) step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("pre-reset rvalid", {31'h0, rvalid}, 32'h1);
    en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async rst rvalid", {31'h0, rvalid}, 32'h0);
    chk("async rst rdata", rdata, 32'h0);
    chk("async rst rd_cnt", rd_cnt, 32'h0);
    chk("async rst wr_cnt", wr_cnt, 32'h0);
    chk("async rst err", {31'h0, err_oob}, 32'h0);
    do_reset();

    // ---- table vectors ----
    for (int k = 0; k < NV + LAT - 1; k++) begin
      if (k < NV) begin
        en = tbl[k].en; we = tbl[k].we; addr = tbl[k].addr; wdata = tbl[k].wd;
      end else begin
        en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
      end
      tick();
      j  = k - (LAT - 1);
      ev = (j >= 0) ? tbl[j].ev : 1'b0;
      ed = (j >= 0) ? tbl[j].ed : 32'h0;
      chk($sformatf("tbl%0d rvalid", k), {31'h0, rvalid}, {31'h0, ev});
      chk($sformatf("tbl%0d rdata", k), rdata, ed);
    end
    chk("tbl rd_cnt", rd_cnt, 32'd6);
    chk("tbl wr_cnt", wr_cnt, 32'd6);
    chk("tbl err", {31'h0, err_oob}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
